// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with single-cycle base ops and optional iterative multiply/divide.
// Define SEQ_ALU_MULDIV_EN to build the M ops; when undefined every op[4]=1 code returns 0 in one cycle.
module seq_alu #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);
    localparam int unsigned SHW = $clog2(XLEN);

`ifdef SEQ_ALU_MULDIV_EN
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
`else
    typedef enum logic {IDLE, DONE} state_t;
`endif

    state_t          state_q, state_d, issue_state;
    logic [XLEN-1:0] result_q;
    logic [XLEN-1:0] base_res, single_res;
    logic [SHW-1:0]  shamt;
    logic            accept;

    assign accept = in_valid & in_ready;
    assign shamt  = b[SHW-1:0];
    assign result = result_q;

    always_comb begin
        base_res = '0;
        case (op[3:0])
            4'b0000: base_res = a + b;
            4'b1000: base_res = a - b;
            4'b0111: base_res = a & b;
            4'b0110: base_res = a | b;
            4'b0100: base_res = a ^ b;
            4'b0011: base_res = {{(XLEN-1){1'b0}}, (a < b)};
            4'b0010: base_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            4'b0001: base_res = a << shamt;
            4'b0101: base_res = a >> shamt;
            4'b1101: base_res = $signed(a) >>> shamt;
            4'b1111: base_res = b;
            default: base_res = '0;
        endcase
    end

`ifdef SEQ_ALU_MULDIV_EN
    logic                is_mul, is_div, div_signed, rem_op;
    logic                div_zero, div_ovf, div_special;
    logic                a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN-1:0]     opnd_q;
    logic [SHW-1:0]      count_q;
    logic                neg_q, sel_q, last_iter;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next, mul_prod;
    logic [XLEN-1:0]     mul_res;
    logic                div_ge;
    logic [XLEN-1:0]     div_trial, div_sel, div_res;
    logic [2*XLEN-1:0]   div_next;

    always_comb begin
        is_mul      = op[4] & ~op[3] & ~op[2];
        is_div      = op[4] & ~op[3] & op[2];
        div_signed  = ~op[0];
        rem_op      = op[1];
        a_sgn       = is_mul ? (op[1:0] == 2'b01 || op[1:0] == 2'b10) : div_signed;
        b_sgn       = is_mul ? (op[1:0] == 2'b01) : div_signed;
        a_neg       = a_sgn & a[XLEN-1];
        b_neg       = b_sgn & b[XLEN-1];
        a_mag       = a_neg ? -a : a;
        b_mag       = b_neg ? -b : b;
        div_zero    = (b == '0);
        div_ovf     = div_signed & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
        div_special = is_div & (div_zero | div_ovf);
    end

    // acc_q holds {high, low}: product/multiplier for MUL, remainder/quotient for DIV
    always_comb begin
        last_iter = (count_q == SHW'(XLEN-1));
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        mul_prod  = neg_q ? -mul_next : mul_next;
        mul_res   = sel_q ? mul_prod[2*XLEN-1:XLEN] : mul_prod[XLEN-1:0];
        div_ge    = acc_q[2*XLEN-1:XLEN-1] >= {1'b0, opnd_q};
        div_trial = acc_q[2*XLEN-2:XLEN-1] - opnd_q;
        div_next  = div_ge ? {div_trial, acc_q[XLEN-2:0], 1'b1} : {acc_q[2*XLEN-2:0], 1'b0};
        div_sel   = sel_q ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
        div_res   = neg_q ? -div_sel : div_sel;
    end
`endif

    always_comb begin
        single_res  = '0;
        issue_state = DONE;
        if (!op[4]) begin
            single_res = base_res;
        end
`ifdef SEQ_ALU_MULDIV_EN
        else if (div_special) begin
            single_res = div_zero ? (rem_op ? a : '1) : (rem_op ? '0 : a);
        end
        if (is_mul) begin
            issue_state = MUL;
        end else if (is_div && !div_special) begin
            issue_state = DIV;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = issue_state;
            DONE: begin
                if (accept) begin
                    state_d = issue_state;
                end else if (out_ready) begin
                    state_d = IDLE;
                end
            end
`ifdef SEQ_ALU_MULDIV_EN
            MUL, DIV: if (last_iter) state_d = DONE;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_q == DONE);
        in_ready  = !rst && (state_q == IDLE || (state_q == DONE && out_ready));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
`ifdef SEQ_ALU_MULDIV_EN
            acc_q    <= '0;
            opnd_q   <= '0;
            count_q  <= '0;
            neg_q    <= 1'b0;
            sel_q    <= 1'b0;
`endif
        end else if (accept) begin
            if (issue_state == DONE) begin
                result_q <= single_res;
            end
`ifdef SEQ_ALU_MULDIV_EN
            acc_q   <= {{XLEN{1'b0}}, (is_mul ? b_mag : a_mag)};
            opnd_q  <= is_mul ? a_mag : b_mag;
            count_q <= '0;
            neg_q   <= (is_div & rem_op) ? a_neg : (a_neg ^ b_neg);
            sel_q   <= is_mul ? (op[1:0] != 2'b00) : rem_op;
`endif
        end
`ifdef SEQ_ALU_MULDIV_EN
        else if (state_q == MUL) begin
            acc_q   <= mul_next;
            count_q <= count_q + 1'b1;
            if (last_iter) begin
                result_q <= mul_res;
            end
        end else if (state_q == DIV) begin
            acc_q   <= div_next;
            count_q <= count_q + 1'b1;
            if (last_iter) begin
                result_q <= div_res;
            end
        end
`endif
    end

endmodule
